// File: rtl/gpr_wb_queue_if.sv
// Writeback bus between the ld/alu producers, the register-file write port and decode's bypass lookup.
// The queue takes the slave side; whoever drives the producers and read addresses takes the master side.
interface gpr_wb_queue_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic          ld_wr_valid;
    logic          ld_wr_ready;
    logic [AW-1:0] ld_wr_addr;
    logic [DW-1:0] ld_wr_data;

    logic          alu_wr_valid;
    logic          alu_wr_ready;
    logic [AW-1:0] alu_wr_addr;
    logic [DW-1:0] alu_wr_data;

    logic          gpr_wren;
    logic [AW-1:0] gpr_addr_c;
    logic [DW-1:0] gpr_data_c;

    logic [AW-1:0] rd_addr_a;
    logic [AW-1:0] rd_addr_b;
    logic          fwd_hit_a;
    logic [DW-1:0] fwd_data_a;
    logic          fwd_hit_b;
    logic [DW-1:0] fwd_data_b;

    logic          q_empty;
    logic          q_full;

    modport slave (
        input  ld_wr_valid, ld_wr_addr, ld_wr_data,
        input  alu_wr_valid, alu_wr_addr, alu_wr_data,
        input  rd_addr_a, rd_addr_b,
        output ld_wr_ready, alu_wr_ready,
        output gpr_wren, gpr_addr_c, gpr_data_c,
        output fwd_hit_a, fwd_data_a, fwd_hit_b, fwd_data_b,
        output q_empty, q_full
    );

    modport master (
        output ld_wr_valid, ld_wr_addr, ld_wr_data,
        output alu_wr_valid, alu_wr_addr, alu_wr_data,
        output rd_addr_a, rd_addr_b,
        input  ld_wr_ready, alu_wr_ready,
        input  gpr_wren, gpr_addr_c, gpr_data_c,
        input  fwd_hit_a, fwd_data_a, fwd_hit_b, fwd_data_b,
        input  q_empty, q_full
    );
endinterface

// File: rtl/gpr_wb_queue.sv
// In-order writeback queue in front of the register file's single write port.
// Drains one entry per cycle and offers the newest pending value for each read address.
module gpr_wb_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input logic           clk,
    input logic           rst,
    gpr_wb_queue_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [CW-1:0] COUNT_FULL  = CW'(DEPTH);
    localparam logic [CW-1:0] COUNT_ROOM2 = CW'(DEPTH - 2);

    logic [AW-1:0] entryAddr_q [DEPTH];
    logic [DW-1:0] entryData_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic          ldReady;
    logic          aluReady;
    logic          ldEnq;
    logic          aluEnq;
    logic          pop;
    logic [PW-1:0] aluSlot;

    // Readiness looks only at the registered count, so a pop this cycle never frees a slot early.
    assign ldReady  = (count_q != COUNT_FULL);
    assign aluReady = bus.ld_wr_valid ? (count_q <= COUNT_ROOM2) : (count_q != COUNT_FULL);
    assign pop      = (count_q != '0);

    always_comb begin
        ldEnq   = bus.ld_wr_valid  && ldReady  && (bus.ld_wr_addr  != '0);
        aluEnq  = bus.alu_wr_valid && aluReady && (bus.alu_wr_addr != '0);
        aluSlot = ldEnq ? (tail_q + PW'(1)) : tail_q;
        head_d  = head_q + PW'(pop);
        tail_d  = tail_q + PW'(ldEnq) + PW'(aluEnq);
        count_d = count_q + CW'(ldEnq) + CW'(aluEnq) - CW'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entryAddr_q[i] <= '0;
                entryData_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (ldEnq) begin
                entryAddr_q[tail_q] <= bus.ld_wr_addr;
                entryData_q[tail_q] <= bus.ld_wr_data;
            end
            if (aluEnq) begin
                entryAddr_q[aluSlot] <= bus.alu_wr_addr;
                entryData_q[aluSlot] <= bus.alu_wr_data;
            end
        end
    end

    assign bus.ld_wr_ready  = ldReady;
    assign bus.alu_wr_ready = aluReady;
    assign bus.gpr_wren     = pop;
    assign bus.gpr_addr_c   = pop ? entryAddr_q[head_q] : '0;
    assign bus.gpr_data_c   = pop ? entryData_q[head_q] : '0;
    assign bus.q_empty      = (count_q == '0);
    assign bus.q_full       = (count_q == COUNT_FULL);

    // Walk from oldest to newest so a later match overrides an earlier one.
    logic          hitA, hitB;
    logic [DW-1:0] dataA, dataB;
    logic [PW-1:0] idx;

    always_comb begin
        hitA  = 1'b0;
        hitB  = 1'b0;
        dataA = '0;
        dataB = '0;
        idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if (CW'(i) < count_q) begin
                if ((bus.rd_addr_a != '0) && (entryAddr_q[idx] == bus.rd_addr_a)) begin
                    hitA  = 1'b1;
                    dataA = entryData_q[idx];
                end
                if ((bus.rd_addr_b != '0) && (entryAddr_q[idx] == bus.rd_addr_b)) begin
                    hitB  = 1'b1;
                    dataB = entryData_q[idx];
                end
            end
        end
    end

    assign bus.fwd_hit_a  = hitA;
    assign bus.fwd_data_a = dataA;
    assign bus.fwd_hit_b  = hitB;
    assign bus.fwd_data_b = dataB;

    count_in_range: assert property (@(posedge clk) disable iff (rst) count_q <= COUNT_FULL);
endmodule
